// File: rtl/aes_key_unexpand.sv
// Inverse AES-128 key schedule: starts from the round-NR key and walks back to round 0,
// presenting one round key per valid/ready handshake.
module aes_key_unexpand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        STEP
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     idx_q, idx_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    w1_prev, w2_prev, w3_prev, w0_prev;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [7:0]     rcon;
    logic [127:0]   prev_key;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign w3_prev  = w3 ^ w2;
    assign w2_prev  = w2 ^ w1;
    assign w1_prev  = w1 ^ w0;
    assign rot_word = {w3_prev[23:0], w3_prev[31:24]};

    // ~b selects entry b because the table is stored MSB-first.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[gi*8 +: 8] = SBOX[{~rot_word[gi*8 +: 8], 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        rcon = 8'h00;
        case (idx_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0_prev  = w0 ^ sub_word ^ {rcon, 24'h000000};
    assign prev_key = {w0_prev, w1_prev, w2_prev, w3_prev};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    key_d   = last_key;
                    idx_d   = 4'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (valid_q && key_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == 4'd0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                key_d   = prev_key;
                idx_d   = idx_q - 4'd1;
                valid_d = 1'b1;
                state_d = EMIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign key_valid = valid_q;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_unexpand.sv
// Bench for aes_key_unexpand: FIPS-197 key schedule unwound with a scoreboard,
// plus backpressure, ignored start, async abort, NR=1 and back-to-back sequences.
module tb_aes_key_unexpand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] last_key = '0;
    logic         key_ready = 1'b1;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    logic         s1 = 1'b0;
    logic [127:0] lk1 = '0;
    logic         kr1 = 1'b1;
    logic         kv1;
    logic [127:0] rk1;
    logic [3:0]   ri1;
    logic         b1;
    logic         d1;

    aes_key_unexpand #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
        .key_ready(key_ready), .key_valid(key_valid), .round_key(round_key),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    aes_key_unexpand #(.NR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .last_key(lk1),
        .key_ready(kr1), .key_valid(kv1), .round_key(rk1),
        .round_idx(ri1), .busy(b1), .done(d1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } vec_t;

    vec_t vecs[11];
    vec_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor plus hold-under-backpressure check.
    initial begin
        logic         prev_kv;
        logic         prev_kr;
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        vec_t         e;
        prev_kv  = 1'b0;
        prev_kr  = 1'b0;
        prev_key = '0;
        prev_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_kv = 1'b0;
            end else begin
                if (prev_kv && !prev_kr && key_valid) begin
                    chk("hold_key", round_key, prev_key);
                    chk("hold_idx", 128'(round_idx), 128'(prev_idx));
                end
                if (done) done_cnt++;
                if (key_valid && key_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: got idx %0d want no key", round_idx);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("key_r%0d", e.idx), round_key, e.key);
                        chk($sformatf("idx_r%0d", e.idx), 128'(round_idx), 128'(e.idx));
                        $display("accept idx=%0d key=%h", round_idx, round_key);
                    end
                end
                prev_kv  = key_valid;
                prev_kr  = key_ready;
                prev_key = round_key;
                prev_idx = round_idx;
            end
        end
    end

    task automatic launch();
        @(posedge clk);
        #1;
        start    = 1'b1;
        last_key = vecs[10].key;
        for (int i = 10; i >= 0; i--) sb_q.push_back(vecs[i]);
        @(posedge clk);
        #1;
        start    = 1'b0;
        last_key = 128'h0123456789abcdef0123456789abcdef;
    endtask

    // Entered #1 after the edge that sampled start; returns at the negedge of the done cycle
    // (or right after an abort).
    task automatic drain(input bit rnd, input bit mid, input int abort_idx, output bit aborted);
        int n;
        int mid_st;
        bit fin;
        n       = 1;
        mid_st  = 0;
        fin     = 1'b0;
        aborted = 1'b0;
        key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin) begin
            @(negedge clk);
            if (n == 1) begin
                chk("first_valid", 128'(key_valid), 128'd1);
                chk("first_idx", 128'(round_idx), 128'd10);
                chk("first_busy", 128'(busy), 128'd1);
            end
            if (done) begin
                if (!rnd) chk("done_cycle", 128'(n), 128'd22);
                chk("sb_drained", 128'(sb_q.size()), 128'd0);
                chk("busy_at_done", 128'(busy), 128'd0);
                fin = 1'b1;
            end else if (n > 600) begin
                total++;
                bad++;
                $display("FAIL timeout: got n=%0d want done", n);
                fin = 1'b1;
            end else if (abort_idx >= 0 && key_valid && key_ready && round_idx == abort_idx[3:0]) begin
                @(posedge clk);
                #3;
                chk("step_valid", 128'(key_valid), 128'd0);
                chk("step_busy", 128'(busy), 128'd1);
                chk("step_idx", 128'(round_idx), 128'(abort_idx));
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 128'(key_valid), 128'd0);
                chk("rst_busy", 128'(busy), 128'd0);
                chk("rst_done", 128'(done), 128'd0);
                chk("rst_key", round_key, 128'd0);
                chk("rst_idx", 128'(round_idx), 128'd0);
                sb_q.delete();
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                if (mid && key_valid && key_ready && round_idx == 4'd7) mid_st = 1;
                @(posedge clk);
                n++;
                #1;
                if (rnd) key_ready = 1'($urandom_range(0, 1));
                if (mid_st == 1) begin
                    start    = 1'b1;
                    last_key = 128'hdeadbeefcafef00d0badc0de12345678;
                    mid_st   = 2;
                end else if (mid_st == 2) begin
                    start  = 1'b0;
                    mid_st = 0;
                end
            end
        end
    endtask

    initial begin
        bit ab;
        int dc;
        int n;
        vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 128'(key_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_key", round_key, 128'd0);
        chk("reset_idx", 128'(round_idx), 128'd0);
        chk("reset_valid_nr1", 128'(kv1), 128'd0);
        rst_n = 1'b1;

        // Plain FIPS unwind, then confirm done is a single-cycle pulse.
        launch();
        drain(1'b0, 1'b0, -1, ab);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse_len", 128'(done), 128'd0);
        chk("done_count", 128'(done_cnt), 128'd1);

        // Random backpressure.
        launch();
        drain(1'b1, 1'b0, -1, ab);
        key_ready = 1'b1;

        // Start pulsed after key 7 is accepted.
        launch();
        drain(1'b0, 1'b1, -1, ab);

        // Async abort while stepping from round 5, then a fresh run.
        dc = done_cnt;
        launch();
        drain(1'b0, 1'b0, 5, ab);
        chk("aborted", 128'(ab), 128'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_on_abort", 128'(done_cnt), 128'(dc));
        launch();
        drain(1'b0, 1'b0, -1, ab);

        // Back-to-back: start held through the done cycle (ignored) and the next (accepted).
        start    = 1'b1;
        last_key = vecs[10].key;
        @(negedge clk);
        chk("b2b_ignore_done_start", 128'(key_valid), 128'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        last_key = '0;
        for (int i = 10; i >= 0; i--) sb_q.push_back(vecs[i]);
        drain(1'b0, 1'b0, -1, ab);

        // NR=1 instance.
        @(posedge clk);
        #1;
        s1  = 1'b1;
        lk1 = vecs[1].key;
        @(posedge clk);
        #1;
        s1  = 1'b0;
        lk1 = '0;
        n   = 1;
        while (n < 40) begin
            @(negedge clk);
            if (n == 1) begin
                chk("nr1_valid1", 128'(kv1), 128'd1);
                chk("nr1_idx1", 128'(ri1), 128'd1);
                chk("nr1_key1", rk1, vecs[1].key);
                $display("nr1 idx=%0d key=%h", ri1, rk1);
            end
            if (n == 3) begin
                chk("nr1_valid0", 128'(kv1), 128'd1);
                chk("nr1_idx0", 128'(ri1), 128'd0);
                chk("nr1_key0", rk1, vecs[0].key);
                $display("nr1 idx=%0d key=%h", ri1, rk1);
            end
            if (d1) begin
                chk("nr1_done_cycle", 128'(n), 128'd4);
                n = 100;
            end else begin
                @(posedge clk);
                n++;
                #1;
            end
        end
        if (n != 100) begin
            total++;
            bad++;
            $display("FAIL nr1_timeout: got no done want done at cycle 4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_unexpand.md
Name: aes_key_unexpand

Overview:
- Inverse AES-128 key schedule engine for the decryption datapath.
- Takes the round-10 (final) round key produced by the forward expansion and regenerates round keys 10, 9, …, 0 in descending order, one per accepted handshake beat.
- Feeds the inverse-cipher round logic, so no 11×128-bit key store is needed.
- Word/byte layout matches the forward schedule: w0 = key[127:96] … w3 = key[31:0]; byte 0 of each word is its MSB byte; RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.

Parameters:
- NR, 10, number of rounds to unwind; legal 1..10; first key emitted is tagged NR, last is tagged 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- last_key  input  128  round-NR key; captured on the start cycle
- key_ready  input  1  consumer accepts round_key when high with key_valid
- key_valid  output  1  round_key/round_idx are valid
- round_key  output  128  current round key
- round_idx  output  4  round number of round_key (NR down to 0)
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; key_valid=0, busy=0, done=0, round_key=0, round_idx=0. Reset mid-sequence aborts immediately; no partial done.
- FSM states: IDLE, EMIT, STEP.
- IDLE:
  - start=1 → register round_key=last_key, round_idx=NR, key_valid=1, busy=1; go to EMIT. First key is visible one cycle after start.
  - start=0 → remain in IDLE.
- EMIT: hold key_valid=1; round_key and round_idx stay stable until key_valid&key_ready.
  - On accept with round_idx=0: key_valid=0, busy=0, done=1 for one cycle; go to IDLE.
  - On accept with round_idx>0: key_valid=0; go to STEP.
- STEP (single cycle): compute the previous round key from the current (w0..w3), with i=round_idx:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[i],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - SubWord applies the forward AES S-box to each byte (4 combinational S-box lookups).
  - Register the result, round_idx ← i−1, key_valid=1; go to EMIT.
- Throughput: with key_ready held high, one key every 2 cycles; NR+1 keys; done 2·NR+2 cycles after start (start at cycle 0, key NR valid at cycle 1, key 0 accepted at cycle 2·NR+1, done at cycle 2·NR+2).
- start while busy or during the done cycle: ignored, with no effect on state or outputs. start in the IDLE cycle after done is accepted.
- key_ready while key_valid=0: ignored.
- key_ready may be held low indefinitely; outputs stay stable meanwhile.
- Purely synchronous datapath apart from the reset; no combinational path from key_ready to any output.

Test Plan:
- FIPS-197 App. A: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1.
  - Key NR: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Key 9: ac7766f319fadc2128d12941575c006e.
  - Key 1: a0fafe1788542cb123a339392a6c7605.
  - Key 0: 2b7e151628aed2a6abf7158809cf4f3c.
  - round_idx steps 10→0; done exactly at cycle 22.
- Backpressure: same vector, key_ready toggled pseudo-randomly.
  - round_key/round_idx never change while key_valid=1 and key_ready=0.
  - Same 11-key sequence; no duplicates or skips.
- start pulsed mid-sequence (after key 7 accepted) with a different last_key: ignored; sequence continues with the original keys.
- rst_n driven low asynchronously (between clock edges) while in STEP at round_idx=5:
  - All outputs 0 immediately; done never pulses.
  - A fresh start afterwards reproduces the FIPS sequence.
- NR=1 build, last_key=a0fafe1788542cb123a339392a6c7605: emits that key then 2b7e151628aed2a6abf7158809cf4f3c; done at cycle 4.
- Back-to-back: start in the cycle after done; second sequence is correct and its first key is valid one cycle after that start.
